// File: rtl/sb_text_ctrl.sv
// rtl/sb_text_ctrl.sv - system-bus front end for word-addressed maps with a CSR-driven block fill engine
module sb_text_ctrl #(
    parameter int NUM_MAPS = 3,
    parameter int MAP_AW   = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   write_enable_i,
    input  logic [3:0]             mem_be_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            write_data_i,
    output logic                   ready_o,
    output logic [31:0]            read_data_o,
    output logic                   rvalid_o,
    output logic [MAP_AW-1:0]      map_addr_o,
    output logic [NUM_MAPS-1:0]    map_we_o,
    output logic [3:0]             map_be_o,
    output logic [31:0]            map_wdata_o,
    input  logic [NUM_MAPS*32-1:0] map_rdata_i,
    output logic                   fill_busy_o,
    output logic                   irq_o
);

    localparam int         CW         = MAP_AW + 1;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_FILL    = 1'b1;
    localparam logic [3:0] CSR_REGION = 4'(NUM_MAPS);

    logic [0:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_w_target;
    logic [31:0]       r_w_val;
    logic [CW-1:0]     r_w_len;
    logic [3:0]        r_ctrl_tgt;
    logic [31:0]       r_fill_val;
    logic [CW-1:0]     r_fill_len;
    logic              r_err;
    logic              r_done;
    logic              r_irq;
    logic              r_rvalid;
    logic              r_rd_map;
    logic [3:0]        r_rd_region;
    logic [31:0]       r_rd_csr;

    logic [MAP_AW-1:0] w_offset;
    logic [3:0]        w_region;
    logic              w_is_map;
    logic              w_is_csr;
    logic              w_is_unm;
    logic              w_accept;
    logic              w_csr_wr;
    logic              w_wr_ctrl;
    logic              w_wr_val;
    logic              w_wr_stat;
    logic              w_wr_len;
    logic [31:0]       w_be_mask;
    logic [CW-1:0]     w_len_mask;
    logic [3:0]        w_start_tgt;
    logic              w_start;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_err_set;
    logic              w_err_clr;
    logic              w_done_clr;
    logic [CW-1:0]     w_len_eff;
    logic              w_fill_last;
    logic [31:0]       w_csr_rdata;
    logic [31:0]       w_map_rd;
    logic              w_unused_addr;

    assign w_offset      = addr_i[MAP_AW+1:2];
    assign w_region      = addr_i[MAP_AW+5:MAP_AW+2];
    assign w_unused_addr = ^{addr_i[31:MAP_AW+6], addr_i[1:0]};
    assign w_is_map      = (w_region < CSR_REGION);
    assign w_is_csr      = (w_region == CSR_REGION);
    assign w_is_unm      = (w_region > CSR_REGION);

    assign ready_o  = !((r_state == ST_FILL) && w_is_map);
    assign w_accept = req_i & ready_o;

    assign w_csr_wr  = w_accept & w_is_csr & write_enable_i;
    assign w_wr_ctrl = w_csr_wr && (w_offset == MAP_AW'(0));
    assign w_wr_val  = w_csr_wr && (w_offset == MAP_AW'(1));
    assign w_wr_stat = w_csr_wr && (w_offset == MAP_AW'(2));
    assign w_wr_len  = w_csr_wr && (w_offset == MAP_AW'(3));

    assign w_be_mask  = {{8{mem_be_i[3]}}, {8{mem_be_i[2]}}, {8{mem_be_i[1]}}, {8{mem_be_i[0]}}};
    assign w_len_mask = w_be_mask[CW-1:0];

    // START and TARGET live in byte 0; a disabled byte 0 makes the CTRL write a no-op
    assign w_start_tgt = write_data_i[7:4];
    assign w_start     = w_wr_ctrl & mem_be_i[0] & write_data_i[0];
    assign w_start_ok  = w_start && (r_state == ST_IDLE) && (w_start_tgt < CSR_REGION);
    assign w_start_bad = w_start && (r_state == ST_IDLE) && !(w_start_tgt < CSR_REGION);

    assign w_err_set  = (w_accept & w_is_unm) | w_start_bad;
    assign w_err_clr  = w_wr_stat & mem_be_i[0] & write_data_i[1];
    assign w_done_clr = w_wr_stat & mem_be_i[0] & write_data_i[2];

    assign w_len_eff   = (r_w_len == '0) ? {1'b1, {MAP_AW{1'b0}}} : r_w_len;
    assign w_fill_last = (r_state == ST_FILL) && (r_cnt == (w_len_eff - CW'(1)));

    always_comb begin
        w_csr_rdata = 32'h0;
        if (w_offset == MAP_AW'(0)) begin
            w_csr_rdata = {24'h0, r_ctrl_tgt, 4'h0};
        end else if (w_offset == MAP_AW'(1)) begin
            w_csr_rdata = r_fill_val;
        end else if (w_offset == MAP_AW'(2)) begin
            w_csr_rdata = {29'h0, r_done, r_err, (r_state == ST_FILL)};
        end else if (w_offset == MAP_AW'(3)) begin
            w_csr_rdata = 32'(r_fill_len);
        end
    end

    always_comb begin
        w_map_rd = 32'h0;
        for (int i = 0; i < NUM_MAPS; i++) begin
            if (r_rd_region == 4'(i)) begin
                w_map_rd = map_rdata_i[i*32 +: 32];
            end
        end
    end

    assign rvalid_o    = r_rvalid;
    assign read_data_o = !r_rvalid ? 32'h0 : (r_rd_map ? w_map_rd : r_rd_csr);
    assign fill_busy_o = (r_state == ST_FILL);
    assign irq_o       = r_irq;

    // The fill engine owns the shared map port; bus map traffic is stalled by ready_o meanwhile
    always_comb begin
        map_we_o    = '0;
        map_addr_o  = w_offset;
        map_be_o    = mem_be_i;
        map_wdata_o = write_data_i;
        if (r_state == ST_FILL) begin
            map_we_o    = NUM_MAPS'(1) << r_w_target;
            map_addr_o  = r_cnt[MAP_AW-1:0];
            map_be_o    = 4'hF;
            map_wdata_o = r_w_val;
        end else if (w_accept && w_is_map && write_enable_i) begin
            map_we_o = NUM_MAPS'(1) << w_region;
        end
        if (!rst_i) begin
            map_we_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_w_target  <= '0;
            r_w_val     <= '0;
            r_w_len     <= '0;
            r_ctrl_tgt  <= '0;
            r_fill_val  <= '0;
            r_fill_len  <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_irq       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rd_map    <= 1'b0;
            r_rd_region <= '0;
            r_rd_csr    <= '0;
        end else begin
            r_irq       <= 1'b0;
            r_rvalid    <= w_accept & ~write_enable_i;
            r_rd_map    <= w_is_map;
            r_rd_region <= w_region;
            r_rd_csr    <= w_is_csr ? w_csr_rdata : 32'h0;

            if (w_wr_ctrl && mem_be_i[0]) begin
                r_ctrl_tgt <= w_start_tgt;
            end
            if (w_wr_val) begin
                r_fill_val <= (r_fill_val & ~w_be_mask) | (write_data_i & w_be_mask);
            end
            if (w_wr_len) begin
                r_fill_len <= (r_fill_len & ~w_len_mask) | (write_data_i[CW-1:0] & w_len_mask);
            end

            // Hardware set events take priority over a coincident write-1-to-clear
            r_err  <= w_err_set | (r_err & ~w_err_clr);
            r_done <= w_fill_last | (r_done & ~w_done_clr);

            if (r_state == ST_IDLE) begin
                if (w_start_ok) begin
                    r_state    <= ST_FILL;
                    r_cnt      <= '0;
                    r_w_target <= w_start_tgt;
                    r_w_val    <= r_fill_val;
                    r_w_len    <= r_fill_len;
                end
            end else begin
                if (w_fill_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_irq   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_text_ctrl.sv
// tb/tb_sb_text_ctrl.sv - scoreboard bench for sb_text_ctrl with behavioural map memories
module tb_sb_text_ctrl;

    localparam int NM = 3;
    localparam int AW = 10;

    localparam logic [31:0] A_CTRL = 32'h0000_3000;
    localparam logic [31:0] A_VAL  = 32'h0000_3004;
    localparam logic [31:0] A_STAT = 32'h0000_3008;
    localparam logic [31:0] A_LEN  = 32'h0000_300C;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic           we;
    logic [3:0]     be;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic           ready;
    logic [31:0]    rdata;
    logic           rvalid;
    logic [AW-1:0]  map_addr;
    logic [NM-1:0]  map_we;
    logic [3:0]     map_be;
    logic [31:0]    map_wdata;
    logic [NM*32-1:0] map_rdata;
    logic           fill_busy;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic        prev_acc  = 1'b0;
    int          idle_err  = 0;
    logic        fill_armed = 1'b0;
    logic [3:0]  f_tgt;
    logic [31:0] f_val;
    int          f_idx = 0;
    int          f_err = 0;
    int          irq_cnt = 0;

    logic [31:0] mem [NM][1024];
    logic [31:0] rd  [NM];

    sb_text_ctrl #(.NUM_MAPS(NM), .MAP_AW(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .req_i          (req),
        .write_enable_i (we),
        .mem_be_i       (be),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .ready_o        (ready),
        .read_data_o    (rdata),
        .rvalid_o       (rvalid),
        .map_addr_o     (map_addr),
        .map_we_o       (map_we),
        .map_be_o       (map_be),
        .map_wdata_o    (map_wdata),
        .map_rdata_i    (map_rdata),
        .fill_busy_o    (fill_busy),
        .irq_o          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign map_rdata = {rd[2], rd[1], rd[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            logic [31:0] w;
            w = mem[i][map_addr];
            if (map_we[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (map_be[b]) w[8*b +: 8] = map_wdata[8*b +: 8];
                end
                mem[i][map_addr] <= w;
            end
            rd[i] <= mem[i][map_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) begin
                logic [31:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                chk("rvalid_latency", 32'(rvalid), 32'd1);
                chk("rdata", rdata, e);
            end else if (rvalid || rdata != 32'h0) begin
                idle_err++;
            end
            prev_acc = req & ready & ~we;
            if (fill_armed && map_we != '0) begin
                if (map_we != (NM'(1) << f_tgt) || map_addr != AW'(f_idx) ||
                    map_wdata != f_val || map_be != 4'hF) f_err++;
                f_idx++;
            end
            if (irq) irq_cnt++;
        end
    end

    function automatic logic [31:0] maddr(input int r, input int off);
        return 32'((r << (AW + 2)) | (off << 2));
    endfunction

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic release_bus;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic wait_ready;
        int n = 0;
        @(negedge clk);
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(a, 1'b1, d, b);
        wait_ready();
        @(posedge clk); #1;
        release_bus();
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] e);
        drive(a, 1'b0, 32'h0, 4'hF);
        wait_ready();
        exp_q.push_back(e);
        @(posedge clk); #1;
        release_bus();
    endtask

    task automatic arm(input logic [3:0] t, input logic [31:0] v);
        f_tgt = t; f_val = v; f_idx = 0; f_err = 0; irq_cnt = 0; fill_armed = 1'b1;
    endtask

    task automatic wait_fill_done;
        int n = 0;
        while (fill_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("fill_end_timeout", 32'(fill_busy), 32'd0);
        @(posedge clk); #1;
        fill_armed = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NM; i++)
            for (int j = 0; j < 1024; j++) mem[i][j] = 32'h0;
        rst_n = 1'b0;
        release_bus();

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_map_we", 32'(map_we), 32'd0);
        chk("rst_busy", 32'(fill_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // bus map write/read
        drive(maddr(0, 5), 1'b1, 32'h41, 4'hF);
        @(negedge clk);
        chk("wr_we", 32'(map_we), 32'h1);
        chk("wr_addr", 32'(map_addr), 32'd5);
        chk("wr_data", map_wdata, 32'h41);
        chk("wr_be", 32'(map_be), 32'hF);
        @(posedge clk); #1;
        release_bus();
        bus_rd(maddr(0, 5), 32'h41);
        bus_rd(maddr(1, 5), 32'h0);
        bus_wr(maddr(2, 7), 32'hAABBCCDD, 4'b0101);
        bus_rd(maddr(2, 7), 32'h00BB00DD);

        // CSR byte enables, then short fill into map 1
        bus_wr(A_VAL, 32'h11223344, 4'hF);
        bus_wr(A_VAL, 32'h00005500, 4'b0010);
        bus_rd(A_VAL, 32'h11225544);
        bus_wr(A_VAL, 32'h20, 4'hF);
        bus_wr(A_LEN, 32'd4, 4'hF);
        arm(4'd1, 32'h20);
        bus_wr(A_CTRL, 32'h11, 4'hF);
        chk("busy_after_start", 32'(fill_busy), 32'd1);
        wait_fill_done();
        chk("fill4_count", 32'(f_idx), 32'd4);
        chk("fill4_seq", 32'(f_err), 32'd0);
        chk("fill4_irq", 32'(irq_cnt), 32'd1);
        bus_rd(A_STAT, 32'h4);
        bus_rd(A_CTRL, 32'h10);
        bus_rd(maddr(1, 3), 32'h20);
        bus_rd(maddr(1, 4), 32'h0);
        bus_wr(A_STAT, 32'h4, 4'hF);
        bus_rd(A_STAT, 32'h0);

        // full-depth fill with a map read stalled behind it
        bus_wr(A_VAL, 32'hDEADBEEF, 4'hF);
        bus_wr(A_LEN, 32'd0, 4'hF);
        arm(4'd0, 32'hDEADBEEF);
        bus_wr(A_CTRL, 32'h01, 4'hF);
        bus_rd(A_STAT, 32'h1);
        drive(maddr(0, 5), 1'b0, 32'h0, 4'hF);
        begin
            int n = 0;
            @(negedge clk);
            chk("ready_held_in_fill", 32'(ready), 32'd0);
            while (!ready && n < 3000) begin
                @(negedge clk);
                n++;
            end
            chk("first_idle_irq", 32'(irq), 32'd1);
            chk("first_idle_busy", 32'(fill_busy), 32'd0);
        end
        exp_q.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        release_bus();
        fill_armed = 1'b0;
        @(negedge clk);
        chk("fill1024_count", 32'(f_idx), 32'd1024);
        chk("fill1024_seq", 32'(f_err), 32'd0);
        chk("fill1024_irq", 32'(irq_cnt), 32'd1);
        @(posedge clk); #1;
        bus_rd(maddr(0, 1023), 32'hDEADBEEF);
        bus_wr(A_STAT, 32'h4, 4'hF);

        // bad target and unmapped access
        bus_wr(A_CTRL, 32'h51, 4'hF);
        chk("bad_tgt_no_fill", 32'(fill_busy), 32'd0);
        bus_rd(A_STAT, 32'h2);
        bus_wr(A_STAT, 32'h2, 4'hF);
        bus_rd(A_STAT, 32'h0);
        bus_rd(32'h0000_5000, 32'h0);
        bus_rd(A_STAT, 32'h2);
        bus_wr(A_STAT, 32'h2, 4'hF);
        drive(32'h0000_5004, 1'b1, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("unmapped_wr_we", 32'(map_we), 32'd0);
        @(posedge clk); #1;
        release_bus();
        bus_rd(A_STAT, 32'h2);
        bus_wr(A_STAT, 32'h2, 4'hF);

        // reset in the middle of a fill
        bus_wr(A_VAL, 32'h77, 4'hF);
        bus_wr(A_LEN, 32'd200, 4'hF);
        arm(4'd2, 32'h77);
        bus_wr(A_CTRL, 32'h21, 4'hF);
        begin
            int n = 0;
            @(negedge clk);
            while (!(map_we[2] && map_addr == AW'(100)) && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        #2;
        rst_n = 1'b0;
        fill_armed = 1'b0;
        #1;
        chk("abort_map_we", 32'(map_we), 32'd0);
        chk("abort_busy", 32'(fill_busy), 32'd0);
        chk("abort_irq", 32'(irq), 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_index", 32'(f_idx), 32'd101);
        repeat (3) @(negedge clk);
        chk("abort_no_irq", 32'(irq_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rd(A_STAT, 32'h0);
        bus_rd(A_VAL, 32'h0);
        bus_rd(A_LEN, 32'h0);
        bus_rd(A_CTRL, 32'h0);
        bus_rd(maddr(2, 99), 32'h77);
        bus_rd(maddr(2, 100), 32'h0);
        bus_wr(A_VAL, 32'h55, 4'hF);
        bus_wr(A_LEN, 32'd2, 4'hF);
        arm(4'd2, 32'h55);
        bus_wr(A_CTRL, 32'h21, 4'hF);
        wait_fill_done();
        chk("refill_count", 32'(f_idx), 32'd2);
        chk("refill_seq", 32'(f_err), 32'd0);
        chk("refill_irq", 32'(irq_cnt), 32'd1);
        bus_rd(maddr(2, 0), 32'h55);
        bus_rd(maddr(2, 2), 32'h77);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("idle_outputs", 32'(idle_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
